pe_acc: RTL and testbench

//  Downstream drain stage for one PE column. Consumes the registered product stream
//  (16-bit unsigned, 1-cycle valid strobe, no backpressure) and sums acc_len products

---
 rtl/pe_acc.sv | 200 ++++++++++++++++++++
 tb/tb_pe_acc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc.sv
// pe_acc: drain stage for one PE column.
// Sums acc_len products from the registered product stream into one dot-product
// result and queues each result in a small output FIFO that is drained over a
// valid/ready handshake.
// Optional build macro PE_ACC_SAT_EN: saturating accumulation, plus a per-entry
// saturation bit exported on sat_flag.
//
// Handshake: the head entry is offered with out_vld=1 and is popped on every
// rising edge where out_vld & out_rdy. While out_vld=1 and out_rdy=0 the head
// (out_data and sat_flag) holds steady. The product input has no backpressure:
// each in_vld cycle is one product and is either consumed (in ACC) or ignored.
module pe_acc #(
  parameter int PROD_W     = 16,
  parameter int ACC_W      = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              in_vld,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ACC_W-1:0]  out_data,
  output logic              acc_busy,
  output logic              ovf_err,
`ifdef PE_ACC_SAT_EN
  output logic              sat_flag,
`endif
  output logic              dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // accumulation datapath
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] w_sum_nxt;
  logic [ACC_W-1:0] w_prod_ext;
  logic             w_start_ok;
  logic             w_beat;
  logic             w_last;

  // result FIFO
  logic [ACC_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, in_data};

`ifdef PE_ACC_SAT_EN
  logic [ACC_W:0]   w_add;
  logic             r_sat;
  logic             w_sat_nxt;
  logic             r_sat_mem [FIFO_DEPTH];

  // Once the carry fires the run is pinned at all-ones for its remainder.
  always_comb begin
    w_add     = {1'b0, r_sum} + {1'b0, w_prod_ext};
    w_sat_nxt = r_sat | w_add[ACC_W];
    w_sum_nxt = w_sat_nxt ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
  end
`else
  // Plain modular sum; the carry out of the top bit is simply lost.
  always_comb begin
    w_sum_nxt = r_sum + w_prod_ext;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a zero-length start is not a run; the last beat returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_ACC;
      S_ACC:  if (w_last)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-derived controls and status outputs.
  always_comb begin
    w_start_ok = (r_state == S_IDLE) && start && (acc_len != '0);
    w_beat     = (r_state == S_ACC) && in_vld;
    w_last     = w_beat && (r_cnt == (r_len - LEN_ONE));
    acc_busy   = (r_state == S_ACC);
    dbg_state  = r_state;
  end

  // Run length, beat counter and running sum; all cleared at run boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_len <= acc_len;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_sum <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + LEN_ONE;
      r_sum <= w_sum_nxt;
    end
  end

`ifdef PE_ACC_SAT_EN
  // Saturation marker for the run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_start_ok || w_last) begin
      r_sat <= 1'b0;
    end else if (w_beat) begin
      r_sat <= w_sat_nxt;
    end
  end
`endif

  // FIFO flags: pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
              (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    w_pop   = !w_empty && out_rdy;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    w_push  = w_last && (!w_full || w_pop);
    w_drop  = w_last && w_full && !w_pop;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop) r_ovf    <= 1'b1;
    end
  end

  // FIFO storage; the completed result is the sum including the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef PE_ACC_SAT_EN
        r_sat_mem[i] <= 1'b0;
`endif
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_sum_nxt;
`ifdef PE_ACC_SAT_EN
      r_sat_mem[r_wr_ptr[PTR_W-1:0]] <= w_sat_nxt;
`endif
    end
  end

  // Head presentation: zeros whenever nothing is queued.
  always_comb begin
    out_vld  = !w_empty;
    out_data = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    ovf_err  = r_ovf;
`ifdef PE_ACC_SAT_EN
    sat_flag = !w_empty && r_sat_mem[r_rd_ptr[PTR_W-1:0]];
`endif
  end

endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: directed bench for pe_acc. Two instances share the stimulus:
// u_dut (ACC_W=32) for the main checks and u_dut17 (ACC_W=17) for the wrap /
// saturation case. Build with PE_ACC_SAT_EN defined to cover the saturating build.
module tb_pe_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  acc_len;
  logic        in_vld;
  logic [15:0] in_data;
  logic        out_rdy;

  logic        out_vld;
  logic [31:0] out_data;
  logic        acc_busy;
  logic        ovf_err;
  logic        dbg_state;
  logic        out_vld17;
  logic [16:0] out_data17;
  logic        acc_busy17;
  logic        ovf_err17;
  logic        dbg_state17;
`ifdef PE_ACC_SAT_EN
  logic        sat_flag;
  logic        sat_flag17;
`endif

  int n_checks;
  int n_fail;

  pe_acc #(.PROD_W(16), .ACC_W(32), .LEN_W(8), .FIFO_DEPTH(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_len   (acc_len),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .acc_busy  (acc_busy),
    .ovf_err   (ovf_err),
`ifdef PE_ACC_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .dbg_state (dbg_state)
  );

  pe_acc #(.PROD_W(16), .ACC_W(17), .LEN_W(8), .FIFO_DEPTH(2)) u_dut17 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_len   (acc_len),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .out_vld   (out_vld17),
    .out_rdy   (out_rdy),
    .out_data  (out_data17),
    .acc_busy  (acc_busy17),
    .ovf_err   (ovf_err17),
`ifdef PE_ACC_SAT_EN
    .sat_flag  (sat_flag17),
`endif
    .dbg_state (dbg_state17)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: step past the rising edge, then inputs and samples settle at +1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [7:0] len);
    start   = 1'b1;
    acc_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input logic [15:0] v);
    in_vld  = 1'b1;
    in_data = v;
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    acc_len  = '0;
    in_vld   = 1'b0;
    in_data  = '0;
    out_rdy  = 1'b1;
    repeat (2) tick();
    check("rst_out_vld",  {31'd0, out_vld},  32'd0);
    check("rst_out_data", out_data,          32'd0);
    check("rst_busy",     {31'd0, acc_busy}, 32'd0);
    check("rst_ovf",      {31'd0, ovf_err},  32'd0);
    rst = 1'b0;
    tick();

    // T1: 3+5+7+9 back to back
    do_start(8'd4);
    check("t1_busy", {31'd0, acc_busy}, 32'd1);
    in_vld = 1'b1;
    in_data = 16'd3; tick();
    in_data = 16'd5; tick();
    in_data = 16'd7; tick();
    check("t1_no_early_vld", {31'd0, out_vld}, 32'd0);
    in_data = 16'd9; tick();
    check("t1_vld",  {31'd0, out_vld},  32'd1);
    check("t1_data", out_data,          32'd24);
    check("t1_idle", {31'd0, acc_busy}, 32'd0);
    // start right after the last beat is accepted; the product on that edge is not
    start = 1'b1; acc_len = 8'd1; in_data = 16'd99;
    tick();
    start = 1'b0;
    check("t1_pulse_end", {31'd0, out_vld},  32'd0);
    check("t1_restart",   {31'd0, acc_busy}, 32'd1);
    in_data = 16'd7; tick();
    in_vld = 1'b0;
    check("t1_b2b_data", out_data, 32'd7);
    tick();

    // T2: 3 x 0xFFFF with 2-cycle gaps
    do_start(8'd3);
    beat(16'hFFFF); tick(); tick();
    check("t2_busy_gap", {31'd0, acc_busy}, 32'd1);
    beat(16'hFFFF); tick(); tick();
    check("t2_busy_gap2", {31'd0, acc_busy}, 32'd1);
    beat(16'hFFFF);
    check("t2_data", out_data,          32'h0002FFFD);
    check("t2_idle", {31'd0, acc_busy}, 32'd0);
    tick();

    // T3: stall output, three single-product runs, third is dropped
    out_rdy = 1'b0;
    do_start(8'd1); beat(16'd1);
    do_start(8'd1); beat(16'd2);
    check("t3_ovf_before", {31'd0, ovf_err}, 32'd0);
    do_start(8'd1); beat(16'd3);
    check("t3_ovf",  {31'd0, ovf_err}, 32'd1);
    check("t3_hold", out_data,         32'd1);
    tick();
    check("t3_hold2", out_data, 32'd1);
    out_rdy = 1'b1;
    check("t3_head1", out_data, 32'd1);
    tick();
    check("t3_head2", out_data, 32'd2);
    tick();
    check("t3_empty_vld",  {31'd0, out_vld}, 32'd0);
    check("t3_empty_data", out_data,         32'd0);
    check("t3_ovf_sticky", {31'd0, ovf_err}, 32'd1);

    // T4: full FIFO, completion and pop on the same edge
    pulse_rst();
    check("t4_ovf_cleared", {31'd0, ovf_err}, 32'd0);
    out_rdy = 1'b0;
    do_start(8'd1); beat(16'd10);
    do_start(8'd1); beat(16'd20);
    do_start(8'd1);
    in_vld = 1'b1; in_data = 16'd30; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    check("t4_ovf",  {31'd0, ovf_err}, 32'd0);
    check("t4_vld",  {31'd0, out_vld}, 32'd1);
    check("t4_head", out_data,         32'd20);
    tick();
    check("t4_tail", out_data, 32'd30);
    tick();
    check("t4_empty", {31'd0, out_vld}, 32'd0);

    // T5: reset mid-run with a result queued
    out_rdy = 1'b0;
    do_start(8'd1); beat(16'd9);
    do_start(8'd4); beat(16'd4); beat(16'd4);
    rst = 1'b1;
    #1;
    check("t5_vld",  {31'd0, out_vld},  32'd0);
    check("t5_data", out_data,          32'd0);
    check("t5_busy", {31'd0, acc_busy}, 32'd0);
    check("t5_ovf",  {31'd0, ovf_err},  32'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    tick();
    do_start(8'd2); beat(16'd1); beat(16'd1);
    check("t5_new_data", out_data, 32'd2);
    tick();

    // T6: 17-bit accumulator, 3 x 0xFFFF
    do_start(8'd3);
    in_vld = 1'b1; in_data = 16'hFFFF;
    tick(); tick(); tick();
    in_vld = 1'b0;
    check("t6_vld17", {31'd0, out_vld17}, 32'd1);
`ifdef PE_ACC_SAT_EN
    check("t6_data17", {15'd0, out_data17}, 32'h0001FFFF);
    check("t6_sat17",  {31'd0, sat_flag17}, 32'd1);
    check("t6_sat32",  {31'd0, sat_flag},   32'd0);
`else
    check("t6_data17", {15'd0, out_data17}, 32'h0000FFFD);
`endif
    check("t6_data32", out_data, 32'h0002FFFD);
    tick();
    // zero-length start is ignored, idle products are ignored
    do_start(8'd0);
    check("t6_len0_busy", {31'd0, acc_busy}, 32'd0);
    beat(16'd5);
    check("t6_idle_prod", {31'd0, out_vld}, 32'd0);
    do_start(8'd1); beat(16'd6);
    check("t6_after_len0", out_data, 32'd6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
